// File: rtl/sipo_frame_ctrl.sv
// Serial-frame capture controller: arms on frame_start, shifts WIDTH qualified
// bits (MSB first) plus an optional parity bit, then loads a one-deep output
// buffer that is drained with a valid/ready handshake.
//
// Ports:
//   clk, rst          - clock and synchronous active-high reset
//   frame_start       - begins or restarts a frame
//   serial_in         - serial data, qualified by bit_valid
//   bit_valid         - serial_in is meaningful this cycle
//   data_out          - captured word, first-received bit at MSB
//   data_valid        - buffer holds a word
//   data_ready        - consumer accepts the buffered word
//   parity_err        - parity mismatch for the buffered word
//   overrun           - sticky, a completed word was dropped
//   overrun_clr       - clears overrun (a same-cycle set wins)
//   busy              - a frame is in progress
module sipo_frame_ctrl #(
  parameter int unsigned WIDTH      = 8,
  parameter bit          PARITY_EN  = 1'b1,
  parameter bit          PARITY_ODD = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             frame_start,
  input  logic             serial_in,
  input  logic             bit_valid,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  input  logic             data_ready,
  output logic             parity_err,
  output logic             overrun,
  input  logic             overrun_clr,
  output logic             busy
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   shreg_q, shreg_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   data_out_q, data_out_d;
  logic               data_valid_q, data_valid_d;
  logic               parity_err_q, parity_err_d;
  logic               overrun_q, overrun_d;
  logic               busy_q, busy_d;

  logic               complete_c;
  logic [WIDTH-1:0]   word_c;
  logic               perr_c;
  logic               ov_set_c;

  // Next-state, frame sequencing and output buffer update.
  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    cnt_d        = cnt_q;
    data_out_d   = data_out_q;
    data_valid_d = data_valid_q;
    parity_err_d = parity_err_q;
    overrun_d    = overrun_q;
    complete_c   = 1'b0;
    word_c       = shreg_q;
    perr_c       = 1'b0;
    ov_set_c     = 1'b0;

    case (state_q)
      IDLE: begin
        if (frame_start) begin
          state_d = SHIFT;
          cnt_d   = '0;
          shreg_d = '0;
        end
      end
      SHIFT: begin
        if (frame_start) begin
          // Restart has priority over any bit in the same cycle.
          cnt_d   = '0;
          shreg_d = '0;
        end else if (bit_valid) begin
          shreg_d = {shreg_q[WIDTH-2:0], serial_in};
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            if (PARITY_EN) begin
              state_d = PARITY;
            end else begin
              state_d    = IDLE;
              complete_c = 1'b1;
              word_c     = shreg_d;
            end
          end
        end
      end
      PARITY: begin
        if (frame_start) begin
          state_d = SHIFT;
          cnt_d   = '0;
          shreg_d = '0;
        end else if (bit_valid) begin
          state_d    = IDLE;
          complete_c = 1'b1;
          word_c     = shreg_q;
          perr_c     = ((^shreg_q) ^ serial_in) != PARITY_ODD;
        end
      end
      default: state_d = IDLE;
    endcase

    if (data_valid_q && data_ready) begin
      data_valid_d = 1'b0;
    end

    // A finished word loads if the buffer is empty or draining this edge.
    if (complete_c) begin
      if (!data_valid_q || data_ready) begin
        data_out_d   = word_c;
        parity_err_d = perr_c;
        data_valid_d = 1'b1;
      end else begin
        ov_set_c = 1'b1;
      end
    end

    if (overrun_clr) begin
      overrun_d = 1'b0;
    end
    if (ov_set_c) begin
      overrun_d = 1'b1;
    end

    busy_d = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      shreg_q      <= '0;
      cnt_q        <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      parity_err_q <= 1'b0;
      overrun_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      cnt_q        <= cnt_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      parity_err_q <= parity_err_d;
      overrun_q    <= overrun_d;
      busy_q       <= busy_d;
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign parity_err = parity_err_q;
  assign overrun    = overrun_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_sipo_frame_ctrl.sv
// Bench for sipo_frame_ctrl: three instances (no parity, even, odd) share one
// stimulus stream; a word-level reference model per instance predicts outputs.
module tb_sipo_frame_ctrl;

  localparam int unsigned W    = 8;
  localparam int          NDUT = 3;

  logic clk = 1'b0;
  logic rst, frame_start, serial_in, bit_valid, data_ready, overrun_clr;

  logic [W-1:0] dout [NDUT];
  logic         dv   [NDUT];
  logic         perr [NDUT];
  logic         ov   [NDUT];
  logic         busy [NDUT];

  always #5 clk = ~clk;

  sipo_frame_ctrl #(.WIDTH(W), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) u_dut_np (
    .clk(clk), .rst(rst), .frame_start(frame_start), .serial_in(serial_in),
    .bit_valid(bit_valid), .data_out(dout[0]), .data_valid(dv[0]),
    .data_ready(data_ready), .parity_err(perr[0]), .overrun(ov[0]),
    .overrun_clr(overrun_clr), .busy(busy[0]));

  sipo_frame_ctrl #(.WIDTH(W), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) u_dut_ev (
    .clk(clk), .rst(rst), .frame_start(frame_start), .serial_in(serial_in),
    .bit_valid(bit_valid), .data_out(dout[1]), .data_valid(dv[1]),
    .data_ready(data_ready), .parity_err(perr[1]), .overrun(ov[1]),
    .overrun_clr(overrun_clr), .busy(busy[1]));

  sipo_frame_ctrl #(.WIDTH(W), .PARITY_EN(1'b1), .PARITY_ODD(1'b1)) u_dut_od (
    .clk(clk), .rst(rst), .frame_start(frame_start), .serial_in(serial_in),
    .bit_valid(bit_valid), .data_out(dout[2]), .data_valid(dv[2]),
    .data_ready(data_ready), .parity_err(perr[2]), .overrun(ov[2]),
    .overrun_clr(overrun_clr), .busy(busy[2]));

  int n_cmp = 0;
  int n_err = 0;
  int dv_cnt [NDUT];

  // Reference model: frame progress as a bit count, accumulated value and
  // count of ones; buffer as plain values.
  bit m_active [NDUT];
  int m_n      [NDUT];
  int m_word   [NDUT];
  int m_ones   [NDUT];
  bit m_valid  [NDUT];
  int m_dout   [NDUT];
  bit m_perr   [NDUT];
  bit m_ov     [NDUT];

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_step(input int i);
    bit pen, podd, done, e, ov_set;
    int s;
    pen    = (i != 0);
    podd   = (i == 2);
    done   = 1'b0;
    e      = 1'b0;
    ov_set = 1'b0;
    s      = int'(serial_in);
    if (rst) begin
      m_active[i] = 0; m_n[i] = 0; m_word[i] = 0; m_ones[i] = 0;
      m_valid[i] = 0; m_dout[i] = 0; m_perr[i] = 0; m_ov[i] = 0;
      return;
    end
    if (frame_start) begin
      m_active[i] = 1; m_n[i] = 0; m_word[i] = 0; m_ones[i] = 0;
    end else if (m_active[i] && bit_valid) begin
      if (m_n[i] < int'(W)) begin
        m_word[i] = m_word[i] * 2 + s;
        m_ones[i] += s;
        m_n[i]++;
        if (m_n[i] == int'(W) && !pen) begin
          done = 1; m_active[i] = 0;
        end
      end else begin
        done = 1; m_active[i] = 0;
        e = (((m_ones[i] + s) % 2) != int'(podd));
      end
    end
    if (done) begin
      if (!m_valid[i] || data_ready) begin
        m_dout[i] = m_word[i]; m_perr[i] = e; m_valid[i] = 1;
      end else begin
        ov_set = 1;
      end
    end else if (m_valid[i] && data_ready) begin
      m_valid[i] = 0;
    end
    if (overrun_clr) m_ov[i] = 0;
    if (ov_set)      m_ov[i] = 1;
  endfunction

  // One clock: drive, advance models, sample after the edge and compare.
  task automatic cyc(input bit fs, input bit sin, input bit bv);
    frame_start = fs;
    serial_in   = sin;
    bit_valid   = bv;
    for (int i = 0; i < NDUT; i++) model_step(i);
    @(posedge clk);
    #1;
    for (int i = 0; i < NDUT; i++) begin
      check($sformatf("dv%0d", i),   int'(dv[i]),   int'(m_valid[i]));
      check($sformatf("busy%0d", i), int'(busy[i]), int'(m_active[i]));
      check($sformatf("ov%0d", i),   int'(ov[i]),   int'(m_ov[i]));
      check($sformatf("dout%0d", i), int'(dout[i]), m_dout[i]);
      check($sformatf("perr%0d", i), int'(perr[i]), int'(m_perr[i]));
      if (dv[i]) dv_cnt[i]++;
    end
  endtask

  // frame_start (with a stray bit_valid that must be ignored) then W bits.
  task automatic send_bits(input logic [W-1:0] w, input int gap_max);
    logic [W-1:0] wv;
    wv = w;
    cyc(1'b1, 1'($urandom), 1'b1);
    for (int b = int'(W) - 1; b >= 0; b--) begin
      repeat ($urandom_range(gap_max, 0)) cyc(1'b0, 1'($urandom), 1'b0);
      cyc(1'b0, wv[b], 1'b1);
    end
  endtask

  // Trailing bit: even-parity-correct unless flip is set.
  task automatic send_parity(input logic [W-1:0] w, input bit flip);
    cyc(1'b0, (^w) ^ flip, 1'b1);
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; frame_start = 1'b0; serial_in = 1'b0; bit_valid = 1'b0;
    data_ready = 1'b0; overrun_clr = 1'b0;
    for (int i = 0; i < NDUT; i++) dv_cnt[i] = 0;
    idle(2);
    rst = 1'b0;
    idle(1);
    check("rst_dout", int'(dout[1]), 0);
    check("rst_dv",   int'(dv[1]),   0);
    check("rst_busy", int'(busy[1]), 0);
    check("rst_ov",   int'(ov[1]),   0);

    // Basic capture, no-parity latency and parity outcomes.
    data_ready = 1'b1;
    send_bits(8'hB2, 0);
    check("np_dv",    int'(dv[0]),   1);
    check("np_dout",  int'(dout[0]), 'hB2);
    check("np_busy",  int'(busy[0]), 0);
    check("ev_busy",  int'(busy[1]), 1);
    send_parity(8'hB2, 1'b0);
    check("ev_dv",    int'(dv[1]),   1);
    check("ev_dout",  int'(dout[1]), 'hB2);
    check("ev_perr0", int'(perr[1]), 0);
    check("od_perr",  int'(perr[2]), 1);
    idle(2);
    send_bits(8'hB2, 0);
    send_parity(8'hB2, 1'b1);
    check("ev_perr1", int'(perr[1]), 1);
    check("ev_dout1", int'(dout[1]), 'hB2);
    idle(2);

    // Gapped bits, consumer stalls for 5 cycles.
    data_ready = 1'b0;
    send_bits(8'h5A, 3);
    send_parity(8'h5A, 1'b0);
    repeat (5) begin
      cyc(1'b0, 1'b0, 1'b0);
      check("hold_dv",   int'(dv[1]),   1);
      check("hold_dout", int'(dout[1]), 'h5A);
    end
    data_ready = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);
    check("drain_dv", int'(dv[1]), 0);
    idle(2);

    // Overrun, clear, then reload on the draining edge.
    data_ready = 1'b0;
    send_bits(8'h11, 1); send_parity(8'h11, 1'b0);
    send_bits(8'h22, 1); send_parity(8'h22, 1'b0);
    check("ovr_dout", int'(dout[1]), 'h11);
    check("ovr_set",  int'(ov[1]),   1);
    overrun_clr = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);
    overrun_clr = 1'b0;
    check("ovr_clr", int'(ov[1]), 0);
    send_bits(8'h33, 0);
    data_ready = 1'b1;
    send_parity(8'h33, 1'b0);
    check("reload_dv",   int'(dv[1]),   1);
    check("reload_dout", int'(dout[1]), 'h33);
    idle(2);
    overrun_clr = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);
    overrun_clr = 1'b0;

    // Mid-frame restart yields exactly one word.
    for (int i = 0; i < NDUT; i++) dv_cnt[i] = 0;
    cyc(1'b1, 1'b0, 1'b0);
    repeat (5) cyc(1'b0, 1'($urandom), 1'b1);
    send_bits(8'hC3, 0);
    send_parity(8'hC3, 1'b0);
    idle(2);
    check("rs_words1", dv_cnt[1], 1);
    check("rs_words0", dv_cnt[0], 1);
    check("rs_dout",   int'(dout[1]), 'hC3);
    check("rs_ov",     int'(ov[1]), 0);

    // Reset mid-frame with a word pending.
    data_ready = 1'b0;
    send_bits(8'h96, 0); send_parity(8'h96, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    repeat (3) cyc(1'b0, 1'b1, 1'b1);
    rst = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    check("mrst_dv",   int'(dv[1]),   0);
    check("mrst_dout", int'(dout[1]), 0);
    check("mrst_busy", int'(busy[1]), 0);
    check("mrst_perr", int'(perr[1]), 0);
    for (int i = 0; i < NDUT; i++) dv_cnt[i] = 0;
    data_ready = 1'b1;
    repeat (10) cyc(1'b0, 1'($urandom), 1'b1);
    check("mrst_noword1", dv_cnt[1], 0);
    check("mrst_noword0", dv_cnt[0], 0);

    // Randomized traffic against the model.
    repeat (600) begin
      rst         = ($urandom_range(99, 0) == 0);
      data_ready  = 1'($urandom);
      overrun_clr = ($urandom_range(7, 0) == 0);
      cyc(($urandom_range(13, 0) == 0), 1'($urandom), ($urandom_range(3, 0) != 0));
    end
    rst = 1'b0; overrun_clr = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sipo_frame_ctrl.md
Name: sipo_frame_ctrl

Overview:
Serial-frame capture controller that sequences a WIDTH-bit serial-in/parallel-out shift register. It arms on a frame-start pulse, shifts exactly WIDTH qualified data bits and optionally one parity bit, then transfers the word into a one-deep output buffer. Downstream logic drains the buffer with a valid/ready handshake. It sits between a bit-level front end (deserialiser or line sampler) and word-level consumers.

Parameters:
WIDTH, 8, data bits per frame (>= 2)
PARITY_EN, 1, 1 = frame carries one trailing parity bit after the data bits
PARITY_ODD, 0, 0 = even parity expected, 1 = odd parity expected

Ports:
clk  input  1  system clock, all logic on posedge
rst  input  1  synchronous, active-high reset
frame_start  input  1  one-cycle pulse that begins (or restarts) a frame
serial_in  input  1  serial data bit, sampled only when bit_valid=1
bit_valid  input  1  qualifies serial_in for this cycle
data_out  output  WIDTH  captured word; first-received bit at MSB
data_valid  output  1  data_out/parity_err hold a word
data_ready  input  1  consumer accepts word when data_valid=1
parity_err  output  1  parity mismatch for the word on data_out (0 when PARITY_EN=0)
overrun  output  1  sticky: a completed word was dropped
overrun_clr  input  1  clears overrun
busy  output  1  high in SHIFT or PARITY state

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst). Reset: state IDLE, shift register 0, bit counter 0, data_out 0, data_valid 0, parity_err 0, overrun 0, busy 0.
- Shifting: each accepted data bit does shreg <= {shreg[WIDTH-2:0], serial_in}. After WIDTH bits, the first bit is at data_out[WIDTH-1].
- States:
  - IDLE: bit_valid ignored. frame_start -> SHIFT, counter <= 0, shreg <= 0.
  - SHIFT: on bit_valid, shift and counter++. The bit that makes counter reach WIDTH goes -> PARITY if PARITY_EN, else COMPLETE action and -> IDLE.
  - PARITY: on bit_valid, sample the parity bit. Error = (XOR of shreg XOR parity bit) != PARITY_ODD. Then COMPLETE action and -> IDLE.
- COMPLETE action, on the same edge that accepts the final bit:
  - If buffer empty, or data_valid && data_ready this cycle: data_out <= shreg (including the final bit), parity_err <= computed error, data_valid <= 1.
  - Otherwise the word is discarded, overrun <= 1 and the buffer is unchanged.
  - data_valid is therefore high in the cycle after the final-bit edge (latency 1).
- Handshake:
  - data_valid stays high, with data_out and parity_err stable, until an edge where data_ready=1.
  - data_valid then falls, unless a COMPLETE reloads the buffer on that same edge, in which case it stays high.
  - data_ready is ignored while data_valid=0.
- frame_start while in SHIFT or PARITY: the frame is aborted, counter <= 0, shreg <= 0, state SHIFT. No word is produced and no overrun occurs. A bit_valid in the same cycle is discarded (restart has priority).
- frame_start coinciding with the final bit: restart has priority and the frame is aborted.
- bit_valid in IDLE, including in the same cycle as frame_start: ignored.
- overrun: overrun_clr clears it. If a set and a clear occur in the same cycle, set wins.
- busy = (state != IDLE).
- rst asserted mid-frame or with data_valid high: everything returns to reset values on that edge and any pending word is lost.

Test Plan:
- WIDTH=8, PARITY_EN=0, data_ready=1: frame_start, then bits 1,0,1,1,0,0,1,0 on consecutive cycles -> data_valid one cycle after the 8th bit, data_out=8'hB2, busy low the same cycle.
- PARITY_EN=1, even: bits of 8'hB2 (four 1s) then parity bit 0 -> parity_err=0. Repeat with parity bit 1 -> parity_err=1, data_out=8'hB2.
- Gapped bit_valid (random 0-3 idle cycles between bits), data_ready=0 for 5 cycles after valid -> data_out=8'h5A held stable with data_valid=1 until the data_ready edge, then data_valid=0.
- Hold data_ready=0 and complete two frames (8'h11, 8'h22) -> data_out stays 8'h11 and overrun=1. Pulse overrun_clr -> overrun=0. Then complete 8'h33 with data_ready=1 on the final-bit edge -> data_valid stays high and data_out=8'h33.
- Mid-frame restart: frame_start after 5 bits, then 8 bits of 8'hC3 -> exactly one word, 8'hC3, and overrun=0.
- rst for 1 cycle after 3 bits with data_valid=1 -> all outputs 0 next cycle. Subsequent bits without frame_start produce no word.
